// File: rtl/up_down_counter.sv
// -----------------------------------------------------------------------------
// up_down_counter
//
// Synchronous binary up/down counter with a direction select and a
// terminal-count flag. It advances by one on every rising clock edge in the
// direction chosen by `mode`.
//
// Build option:
//   UP_DOWN_COUNTER_SAT_EN  undefined (default): wraps modulo 2^WIDTH
//                           defined: saturates at 0 / 2^WIDTH-1
//
// Parameters:
//   WIDTH  counter width in bits (2..32), default 4
//
// Ports:
//   clk    in   1      rising-edge clock, sole clock domain
//   rst    in   1      synchronous active-high reset (clears count)
//   mode   in   1      0 = count up, 1 = count down
//   count  out  WIDTH  current counter value (registered)
//   tc     out  1      terminal count: next step would wrap/hold,
//                      combinational from count and mode, 0 while rst=1
// -----------------------------------------------------------------------------
module up_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;
    logic             at_limit_s;

    // True when the current value is the last one before a wrap in the
    // selected direction.
    function automatic logic is_limit(input logic [WIDTH-1:0] cur,
                                      input logic             down);
        logic lim;
        if (down) begin
            lim = (cur == CNT_ZERO);
        end else begin
            lim = (cur == CNT_MAX);
        end
        return lim;
    endfunction

    // One unsigned modulo-2^WIDTH step in the selected direction.
    function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] cur,
                                                    input logic             down);
        logic [WIDTH-1:0] nxt;
        if (down) begin
            nxt = cur - CNT_ONE;
        end else begin
            nxt = cur + CNT_ONE;
        end
        return nxt;
    endfunction

    // Limit detection, next-state selection and terminal-count flag.
    always_comb begin
        at_limit_s   = is_limit(count_r, mode);
        count_next_s = step_count(count_r, mode);
`ifdef UP_DOWN_COUNTER_SAT_EN
        // Saturating build: hold at the end of the range instead of wrapping.
        if (at_limit_s) begin
            count_next_s = count_r;
        end else begin
            count_next_s = step_count(count_r, mode);
        end
`endif
        // Reset masks the flag even though count already reads 0.
        if (rst) begin
            tc = 1'b0;
        end else begin
            tc = at_limit_s;
        end
    end

    // Counter state register; reset takes priority over counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= CNT_ZERO;
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count = count_r;

endmodule

// File: tb/tb_up_down_counter.sv
// -----------------------------------------------------------------------------
// tb_up_down_counter
//
// Scoreboard bench for up_down_counter. Two instances run side by side:
// WIDTH=4 and WIDTH=8. Stimulus is applied on the falling edge and the
// hand-computed post-edge {count, tc} of both instances is pushed into a
// queue; a monitor process pops and compares one entry one time unit after
// each rising edge. While one instance is exercised, the other is held in
// reset and is expected to read 0 with tc masked.
// Build with +define+UP_DOWN_COUNTER_SAT_EN for the saturating expectations.
// -----------------------------------------------------------------------------
module tb_up_down_counter;

    typedef struct {
        logic [3:0] c4;
        logic       t4;
        logic [7:0] c8;
        logic       t8;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst4, mode4, rst8, mode8;
    logic [3:0] count4;
    logic       tc4;
    logic [7:0] count8;
    logic       tc8;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    up_down_counter #(.WIDTH(4)) dut4 (
        .clk  (clk),
        .rst  (rst4),
        .mode (mode4),
        .count(count4),
        .tc   (tc4)
    );

    up_down_counter #(.WIDTH(8)) dut8 (
        .clk  (clk),
        .rst  (rst8),
        .mode (mode8),
        .count(count8),
        .tc   (tc8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, req, $time);
        end
    endtask

    // Monitor: compare the DUT outputs after every rising edge that has an
    // expectation queued for it.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count4", {28'd0, count4}, {28'd0, e.c4});
            chk("tc4",    {31'd0, tc4},    {31'd0, e.t4});
            chk("count8", {24'd0, count8}, {24'd0, e.c8});
            chk("tc8",    {31'd0, tc8},    {31'd0, e.t8});
        end
    end

    // One cycle on the WIDTH=4 instance; WIDTH=8 instance held in reset.
    task automatic cyc4(input logic r, input logic m, input logic [3:0] c, input logic t);
        exp_t e;
        @(negedge clk);
        rst4 = r;  mode4 = m;
        rst8 = 1'b1; mode8 = 1'b0;
        e.c4 = c; e.t4 = t; e.c8 = 8'd0; e.t8 = 1'b0;
        exp_q.push_back(e);
    endtask

    // One cycle on the WIDTH=8 instance; WIDTH=4 instance held in reset.
    task automatic cyc8(input logic r, input logic m, input logic [7:0] c, input logic t);
        exp_t e;
        @(negedge clk);
        rst8 = r;  mode8 = m;
        rst4 = 1'b1; mode4 = 1'b0;
        e.c4 = 4'd0; e.t4 = 1'b0; e.c8 = c; e.t8 = t;
        exp_q.push_back(e);
    endtask

    initial begin
        rst4 = 1'b1; mode4 = 1'b0; rst8 = 1'b1; mode8 = 1'b0;

        // Reset held 3 edges with mode=0, then count 1,2,3.
        cyc4(1'b1, 1'b0, 4'd0, 1'b0);
        cyc4(1'b1, 1'b0, 4'd0, 1'b0);
        cyc4(1'b1, 1'b0, 4'd0, 1'b0);
        cyc4(1'b0, 1'b0, 4'd1, 1'b0);
        cyc4(1'b0, 1'b0, 4'd2, 1'b0);
        cyc4(1'b0, 1'b0, 4'd3, 1'b0);

`ifndef UP_DOWN_COUNTER_SAT_EN
        // Up to 15 (tc=1 only there) then wrap to 0.
        for (int v = 4; v <= 15; v++) begin
            cyc4(1'b0, 1'b0, 4'(v), (v == 15) ? 1'b1 : 1'b0);
        end
        cyc4(1'b0, 1'b0, 4'd0,  1'b0);
        cyc4(1'b0, 1'b0, 4'd1,  1'b0);
        cyc4(1'b0, 1'b0, 4'd2,  1'b0);
        // Down wrap from 2: 1, 0, 15, 14.
        cyc4(1'b0, 1'b1, 4'd1,  1'b0);
        cyc4(1'b0, 1'b1, 4'd0,  1'b1);
        cyc4(1'b0, 1'b1, 4'd15, 1'b0);
        cyc4(1'b0, 1'b1, 4'd14, 1'b0);
        // Back up: 15, 0, then 1..9.
        cyc4(1'b0, 1'b0, 4'd15, 1'b1);
        cyc4(1'b0, 1'b0, 4'd0,  1'b0);
        for (int v = 1; v <= 9; v++) begin
            cyc4(1'b0, 1'b0, 4'(v), 1'b0);
        end
        // Direction change: 8, 7; mid-count reset holds 0 with tc masked.
        cyc4(1'b0, 1'b1, 4'd8,  1'b0);
        cyc4(1'b0, 1'b1, 4'd7,  1'b0);
        cyc4(1'b1, 1'b1, 4'd0,  1'b0);
        cyc4(1'b1, 1'b1, 4'd0,  1'b0);
        cyc4(1'b0, 1'b1, 4'd15, 1'b0);
        // Reset with a simultaneous mode change: reset wins.
        cyc4(1'b1, 1'b0, 4'd0,  1'b0);
        cyc4(1'b0, 1'b1, 4'd15, 1'b0);

        // WIDTH=8: up from 254 to 255 then 0; down from 0 to 255.
        cyc8(1'b1, 1'b0, 8'd0, 1'b0);
        for (int v = 1; v <= 254; v++) begin
            cyc8(1'b0, 1'b0, 8'(v), 1'b0);
        end
        cyc8(1'b0, 1'b0, 8'd255, 1'b1);
        cyc8(1'b0, 1'b0, 8'd0,   1'b0);
        cyc8(1'b0, 1'b1, 8'd255, 1'b0);
        cyc8(1'b0, 1'b1, 8'd254, 1'b0);
`else
        // Saturating: up to 14, then 15 held with tc=1.
        for (int v = 4; v <= 14; v++) begin
            cyc4(1'b0, 1'b0, 4'(v), 1'b0);
        end
        cyc4(1'b0, 1'b0, 4'd15, 1'b1);
        cyc4(1'b0, 1'b0, 4'd15, 1'b1);
        cyc4(1'b0, 1'b0, 4'd15, 1'b1);
        // Flip to down: 14 .. 1, then 0 held with tc=1.
        for (int v = 14; v >= 1; v--) begin
            cyc4(1'b0, 1'b1, 4'(v), 1'b0);
        end
        cyc4(1'b0, 1'b1, 4'd0, 1'b1);
        cyc4(1'b0, 1'b1, 4'd0, 1'b1);
        cyc4(1'b0, 1'b0, 4'd1, 1'b0);
        // Mid-count reset with tc masked.
        cyc4(1'b1, 1'b1, 4'd0, 1'b0);
        cyc4(1'b0, 1'b1, 4'd0, 1'b1);

        // WIDTH=8 saturating: 254, 255 held, then down to 254; 0 held.
        cyc8(1'b1, 1'b0, 8'd0, 1'b0);
        for (int v = 1; v <= 254; v++) begin
            cyc8(1'b0, 1'b0, 8'(v), 1'b0);
        end
        cyc8(1'b0, 1'b0, 8'd255, 1'b1);
        cyc8(1'b0, 1'b0, 8'd255, 1'b1);
        cyc8(1'b0, 1'b1, 8'd254, 1'b0);
        cyc8(1'b1, 1'b1, 8'd0,   1'b0);
        cyc8(1'b0, 1'b1, 8'd0,   1'b1);
`endif

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
